// File: rtl/midi_msg_parser_if.sv
// Byte-in / message-out bundle between the MIDI receiver, the parser and the synth stage.
interface midi_msg_parser_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       msg_valid;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic       note_on;
    logic       note_off;
    logic [7:0] err_cnt;

    // Byte source side (serial receiver or bench).
    modport master (
        output byte_in, byte_valid,
        input  msg_valid, msg_status, msg_data1, msg_data2, note_on, note_off, err_cnt
    );

    // Parser side.
    modport slave (
        input  byte_in, byte_valid,
        output msg_valid, msg_status, msg_data1, msg_data2, note_on, note_off, err_cnt
    );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message assembler with running status, realtime pass-over,
// system-common discard, optional channel filter and an orphan-data error counter.
module midi_msg_parser #(
    parameter bit         CH_FILTER_EN = 1'b0,
    parameter logic [3:0] CH_SEL       = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    midi_msg_parser_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_D2 = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_rs, w_rs_nxt;
    logic       r_rs_valid, w_rs_valid_nxt;
    logic [6:0] r_data1, w_data1_nxt;

    logic       r_msg_valid;
    logic [7:0] r_msg_status;
    logic [6:0] r_msg_data1;
    logic [6:0] r_msg_data2;
    logic       r_note_on;
    logic       r_note_off;
    logic [7:0] r_err_cnt;

    logic       w_is_data;
    logic       w_is_syscommon;
    logic       w_is_voice;
    logic       w_one_byte;
    logic       w_complete;
    logic       w_emit;
    logic       w_err_inc;
    logic [6:0] w_d1;
    logic [6:0] w_d2;

    // Byte classes; anything with the top five bits all ones is realtime and falls through untouched.
    assign w_is_data      = ~bus.byte_in[7];
    assign w_is_syscommon = (bus.byte_in[7:3] == 5'b11110);
    assign w_is_voice     = bus.byte_in[7] && (bus.byte_in[7:4] != 4'hF);
    // Cn (program change) and Dn (channel pressure) carry a single data byte.
    assign w_one_byte     = (r_rs[7:5] == 3'b110);

    // A completed message is only published when it passes the channel filter.
    assign w_emit = w_complete && (!CH_FILTER_EN || (r_rs[3:0] == CH_SEL));

    // Next-state decode of one received byte.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        w_state_nxt    = r_state;
        w_rs_nxt       = r_rs;
        w_rs_valid_nxt = r_rs_valid;
        w_data1_nxt    = r_data1;
        w_complete     = 1'b0;
        w_err_inc      = 1'b0;
        w_d1           = bus.byte_in[6:0];
        w_d2           = 7'd0;

        if (bus.byte_valid) begin
            if (w_is_voice) begin
                // New status always wins; any half-built message is dropped.
                w_rs_nxt       = bus.byte_in;
                w_rs_valid_nxt = 1'b1;
                w_state_nxt    = S_IDLE;
            end else if (w_is_syscommon) begin
                w_rs_valid_nxt = 1'b0;
                w_state_nxt    = S_DISCARD;
            end else if (w_is_data) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (!r_rs_valid) begin
                            w_err_inc = 1'b1;
                        end else if (w_one_byte) begin
                            w_complete = 1'b1;
                        end else begin
                            w_data1_nxt = bus.byte_in[6:0];
                            w_state_nxt = S_WAIT_D2;
                        end
                    end
                    S_WAIT_D2: begin
                        // Running status stays valid so the next data byte opens a new message.
                        w_complete  = 1'b1;
                        w_d1        = r_data1;
                        w_d2        = bus.byte_in[6:0];
                        w_state_nxt = S_IDLE;
                    end
                    default: ; // S_DISCARD: system-common payload is dropped silently
                endcase
            end
        end
    end

    // Parser state and running-status registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rs       <= 8'h00;
            r_rs_valid <= 1'b0;
            r_data1    <= 7'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rs       <= w_rs_nxt;
            r_rs_valid <= w_rs_valid_nxt;
            r_data1    <= w_data1_nxt;
        end
    end

    // Registered message outputs: pulses for one cycle, fields hold until the next emitted message.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_msg_valid  <= 1'b0;
            r_msg_status <= 8'h00;
            r_msg_data1  <= 7'd0;
            r_msg_data2  <= 7'd0;
            r_note_on    <= 1'b0;
            r_note_off   <= 1'b0;
        end else begin
            r_msg_valid <= w_emit;
            r_note_on   <= w_emit && (r_rs[7:4] == 4'h9) && (w_d2 != 7'd0);
            r_note_off  <= w_emit && ((r_rs[7:4] == 4'h8) ||
                                      ((r_rs[7:4] == 4'h9) && (w_d2 == 7'd0)));
            if (w_emit) begin
                r_msg_status <= r_rs;
                r_msg_data1  <= w_d1;
                r_msg_data2  <= w_d2;
            end
        end
    end

    // Saturating count of data bytes that arrive with no running status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= 8'h00;
        end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.msg_valid  = r_msg_valid;
    assign bus.msg_status = r_msg_status;
    assign bus.msg_data1  = r_msg_data1;
    assign bus.msg_data2  = r_msg_data2;
    assign bus.note_on    = r_note_on;
    assign bus.note_off   = r_note_off;
    assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: an unfiltered instance and a channel-1 filtered instance
// see the same byte stream; expected messages are queued per instance and popped on msg_valid.
module tb_midi_msg_parser;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    midi_msg_parser_if bus0();
    midi_msg_parser_if bus1();

    midi_msg_parser #(.CH_FILTER_EN(1'b0), .CH_SEL(4'd0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    midi_msg_parser #(.CH_FILTER_EN(1'b1), .CH_SEL(4'd1)) u_dut_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct packed {
        logic [7:0] st;
        logic [6:0] d1;
        logic [6:0] d2;
        logic       on;
        logic       off;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;

    task automatic set_inputs(input logic v, input logic [7:0] b);
        bus0.byte_valid = v;
        bus0.byte_in    = b;
        bus1.byte_valid = v;
        bus1.byte_in    = b;
    endtask

    // Compare one instance's outputs against its queue whenever it pulses.
    task automatic check_msg(input int idx, input logic v, input logic [7:0] st,
                             input logic [6:0] d1, input logic [6:0] d2,
                             input logic on, input logic off);
        exp_t e;
        exp_t got;
        got = '{st: st, d1: d1, d2: d2, on: on, off: off};
        if (v) begin
            checks++;
            if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_msg dut%0d: got st=%h d1=%h d2=%h on=%b off=%b, required no message",
                         idx, st, d1, d2, on, off);
            end else begin
                e = (idx == 0) ? q0.pop_front() : q1.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL msg_fields dut%0d: got st=%h d1=%h d2=%h on=%b off=%b, required st=%h d1=%h d2=%h on=%b off=%b",
                             idx, st, d1, d2, on, off, e.st, e.d1, e.d2, e.on, e.off);
                end
            end
        end else if (on || off) begin
            checks++;
            errors++;
            $display("FAIL stray_note_flag dut%0d: got on=%b off=%b without msg_valid, required 0 0", idx, on, off);
        end
    endtask

    task automatic sample();
        check_msg(0, bus0.msg_valid, bus0.msg_status, bus0.msg_data1, bus0.msg_data2, bus0.note_on, bus0.note_off);
        check_msg(1, bus1.msg_valid, bus1.msg_status, bus1.msg_data1, bus1.msg_data2, bus1.note_on, bus1.note_off);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        sample();
        set_inputs(1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sample();
            set_inputs(1'b0, 8'h00);
        end
    endtask

    // Queue a message for the unfiltered instance, and for the filtered one only on channel 1.
    task automatic expect_msg(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                              input logic on, input logic off);
        exp_t e;
        e = '{st: st, d1: d1, d2: d2, on: on, off: off};
        q0.push_back(e);
        if (st[3:0] == 4'd1) q1.push_back(e);
    endtask

    task automatic end_test(input string name);
        idle(2);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d/%0d messages still owed, required 0/0", name, q0.size(), q1.size());
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic check_err(input string name, input logic [7:0] exp_cnt);
        checks++;
        if (bus0.err_cnt !== exp_cnt || bus1.err_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s_err_cnt: got %0d/%0d, required %0d", name, bus0.err_cnt, bus1.err_cnt, exp_cnt);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_inputs(1'b0, 8'h00);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_inputs(1'b0, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus0.msg_valid, bus0.msg_status, bus0.msg_data1, bus0.msg_data2, bus0.note_on, bus0.note_off, bus0.err_cnt} !== 33'd0 ||
            {bus1.msg_valid, bus1.msg_status, bus1.msg_data1, bus1.msg_data2, bus1.note_on, bus1.note_off, bus1.err_cnt} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs: got dut0 st=%h err=%h v=%b dut1 st=%h err=%h v=%b, required all 0",
                     bus0.msg_status, bus0.err_cnt, bus0.msg_valid, bus1.msg_status, bus1.err_cnt, bus1.msg_valid);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_note_on();
        send(8'h90); send(8'h3C);
        expect_msg(8'h90, 7'h3C, 7'h64, 1'b1, 1'b0);
        send(8'h64);
        end_test("note_on");
        checks++;
        if (bus0.msg_status !== 8'h90 || bus0.msg_data1 !== 7'h3C || bus0.msg_data2 !== 7'h64) begin
            errors++;
            $display("FAIL note_on_hold: got %h/%h/%h, required 90/3c/64", bus0.msg_status, bus0.msg_data1, bus0.msg_data2);
        end
    endtask

    task automatic test_running_status();
        send(8'h90); send(8'h3C);
        expect_msg(8'h90, 7'h3C, 7'h64, 1'b1, 1'b0);
        send(8'h64); send(8'h40);
        expect_msg(8'h90, 7'h40, 7'h00, 1'b0, 1'b1);
        send(8'h00);
        end_test("running_status");
    endtask

    task automatic test_realtime();
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE);
        expect_msg(8'h90, 7'h3C, 7'h64, 1'b1, 1'b0);
        send(8'h64); send(8'hFF);
        end_test("realtime");
    endtask

    task automatic test_one_byte();
        send(8'hC5);
        expect_msg(8'hC5, 7'h07, 7'h00, 1'b0, 1'b0);
        send(8'h07);
        expect_msg(8'hC5, 7'h07, 7'h00, 1'b0, 1'b0);
        send(8'h07);
        send(8'hD1);
        expect_msg(8'hD1, 7'h10, 7'h00, 1'b0, 1'b0);
        send(8'h10);
        end_test("one_byte");
    endtask

    task automatic test_note_off_8n();
        send(8'h81); send(8'h3C);
        expect_msg(8'h81, 7'h3C, 7'h40, 1'b0, 1'b1);
        send(8'h40);
        send(8'hE1); send(8'h00);
        expect_msg(8'hE1, 7'h00, 7'h40, 1'b0, 1'b0);
        send(8'h40);
        end_test("note_off_8n");
    endtask

    task automatic test_orphan_syscommon();
        do_reset();
        send(8'h3C); send(8'h64);
        idle(1);
        check_err("orphan", 8'd2);
        send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h3C);
        idle(1);
        check_err("syscommon", 8'd2);
        send(8'h92); send(8'h10);
        expect_msg(8'h92, 7'h10, 7'h20, 1'b1, 1'b0);
        send(8'h20);
        end_test("orphan_syscommon");
    endtask

    task automatic test_filter();
        send(8'h90); send(8'h3C);
        expect_msg(8'h90, 7'h3C, 7'h64, 1'b1, 1'b0);
        send(8'h64);
        send(8'h91); send(8'h3C);
        expect_msg(8'h91, 7'h3C, 7'h64, 1'b1, 1'b0);
        send(8'h64);
        end_test("filter");
        send(8'h90); send(8'h3C); send(8'hB0); send(8'h07);
        expect_msg(8'hB0, 7'h07, 7'h7F, 1'b0, 1'b0);
        send(8'h7F);
        end_test("partial_drop");
        checks++;
        if (bus1.msg_status !== 8'h91 || bus1.msg_data1 !== 7'h3C || bus1.msg_data2 !== 7'h64) begin
            errors++;
            $display("FAIL filter_hold: got %h/%h/%h, required 91/3c/64", bus1.msg_status, bus1.msg_data1, bus1.msg_data2);
        end
    endtask

    task automatic test_back_to_back();
        send(8'h91); send(8'h3C);
        expect_msg(8'h91, 7'h3C, 7'h64, 1'b1, 1'b0);
        send(8'h64);
        expect_msg(8'hC1, 7'h05, 7'h00, 1'b0, 1'b0);
        send(8'hC1); send(8'h05);
        send(8'hB1); send(8'h07);
        expect_msg(8'hB1, 7'h07, 7'h7F, 1'b0, 1'b0);
        send(8'h7F);
        end_test("back_to_back");
    endtask

    task automatic test_reset_mid_message();
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h64);
        idle(1);
        check_err("reset_mid", 8'd1);
        end_test("reset_mid");
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int i = 0; i < 254; i++) send(8'h11);
        idle(1);
        check_err("sat_254", 8'd254);
        send(8'h11);
        idle(1);
        check_err("sat_255", 8'd255);
        for (int i = 0; i < 5; i++) send(8'h11);
        idle(1);
        check_err("sat_hold", 8'd255);
        end_test("err_saturate");
    endtask

    initial begin
        set_inputs(1'b0, 8'h00);
        test_reset();
        test_note_on();
        test_running_status();
        test_realtime();
        test_one_byte();
        test_note_off_8n();
        test_orphan_syscommon();
        test_filter();
        test_back_to_back();
        test_reset_mid_message();
        test_err_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
